// File: rtl/rx_ltssm_exit_evaluator_if.sv
// Bundle of all request, lane and result signals between the main LTSSM and
// the RX exit-condition evaluator.
//   master : LTSSM side; drives start/abort/substate, the lane mask, the
//            per-lane ordered-set pulses, electrical idle and timer expiry,
//            and receives the result and timer controls.
//   slave  : evaluator side (rx_ltssm_exit_evaluator).
interface rx_ltssm_exit_evaluator_if #(
  parameter int MAXLANES = 16
);
  logic                start;
  logic                abort;
  logic [3:0]          substate;
  logic [MAXLANES-1:0] activeLanes;
  logic [MAXLANES-1:0] osValid;
  logic                rxElectricalIdle;
  logic                timeOut;

  logic                busy;
  logic                finish;
  logic                pass;
  logic [3:0]          exitTo;
  logic [2:0]          timeToWait;
  logic                startTimer;
  logic                enableTimer;
  logic [MAXLANES-1:0] osCheckerEnable;

  modport master (
    output start, abort, substate, activeLanes, osValid, rxElectricalIdle, timeOut,
    input  busy, finish, pass, exitTo, timeToWait, startTimer, enableTimer, osCheckerEnable
  );

  modport slave (
    input  start, abort, substate, activeLanes, osValid, rxElectricalIdle, timeOut,
    output busy, finish, pass, exitTo, timeToWait, startTimer, enableTimer, osCheckerEnable
  );
endinterface

// File: rtl/rx_ltssm_exit_evaluator.sv
// RX-side exit-condition evaluator for the PCIe LTSSM.
// On start it arms the external state timer, counts qualifying ordered sets
// on every lane of the latched mask with saturating counters, and reports
// pass/fail plus the next substate with a one-cycle finish pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all state and outputs
//   bus   : slave modport carrying start/abort/substate, lane mask,
//           osValid, rxElectricalIdle, timeOut in and busy/finish/pass/
//           exitTo/timer controls/osCheckerEnable out (all registered)
module rx_ltssm_exit_evaluator #(
  parameter int MAXLANES = 16,
  parameter int CNTW     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  rx_ltssm_exit_evaluator_if.slave  bus
);

  // Comparison width wide enough for both the counter and the 4-bit REQ.
  localparam int CMPW = (CNTW > 4) ? CNTW : 4;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t              state, state_d;
  logic [3:0]          sub_q, sub_d;
  logic [3:0]          req_q, req_d;
  logic [MAXLANES-1:0] mask_q, mask_d;
  logic [CNTW-1:0]     cnt [MAXLANES];
  logic [CNTW-1:0]     cnt_inc [MAXLANES];
  logic [CNTW-1:0]     cnt_d [MAXLANES];

  logic                busy_q, busy_d;
  logic                finish_q, finish_d;
  logic                pass_q, pass_d;
  logic [3:0]          exit_q, exit_d;
  logic [2:0]          ttw_q, ttw_d;
  logic                start_tmr_q, start_tmr_d;
  logic                en_tmr_q, en_tmr_d;
  logic [MAXLANES-1:0] osce_q, osce_d;

  logic met, met_next, success;

  // Required ordered-set count for each evaluated substate.
  function automatic logic [3:0] req_of(input logic [3:0] s);
    case (s)
      4'd2, 4'd3, 4'd8:                    req_of = 4'd8;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd9:        req_of = 4'd2;
      default:                             req_of = 4'd0;
    endcase
  endfunction

  // Timer code: 0=0ms, 1=12ms, 2=24ms, 3=48ms, 4=2ms.
  function automatic logic [2:0] timer_of(input logic [3:0] s);
    case (s)
      4'd0:                                timer_of = 3'd1;
      4'd3:                                timer_of = 3'd3;
      4'd6, 4'd9:                          timer_of = 3'd4;
      4'd2, 4'd4, 4'd5, 4'd7, 4'd8:        timer_of = 3'd2;
      default:                             timer_of = 3'd0;
    endcase
  endfunction

  // Saturating increment of masked lanes, only while counting.
  always_comb begin
    cnt_inc = cnt;
    for (int i = 0; i < MAXLANES; i++) begin
      if (state == COUNT && mask_q[i] && bus.osValid[i] && cnt[i] != {CNTW{1'b1}})
        cnt_inc[i] = cnt[i] + CNTW'(1);
    end
  end

  // met uses the registered counters. met_next looks at this cycle's pulses
  // so that a pulse landing together with timeOut is not reported as a fail;
  // the pass is then reported one cycle later from the registered count.
  always_comb begin
    met      = (mask_q != '0) || (req_q == 4'd0);
    met_next = (mask_q != '0) || (req_q == 4'd0);
    for (int i = 0; i < MAXLANES; i++) begin
      if (mask_q[i]) begin
        if (CMPW'(cnt[i]) < CMPW'(req_q))     met      = 1'b0;
        if (CMPW'(cnt_inc[i]) < CMPW'(req_q)) met_next = 1'b0;
      end
    end
    case (sub_q)
      4'd0:    success = !bus.rxElectricalIdle || bus.timeOut;
      4'd1:    success = bus.timeOut;
      default: success = met;
    endcase
  end

  // Next state and next registered outputs; abort overrides everything.
  always_comb begin
    state_d     = state;
    sub_d       = sub_q;
    req_d       = req_q;
    mask_d      = mask_q;
    cnt_d       = cnt_inc;
    finish_d    = 1'b0;
    pass_d      = pass_q;
    exit_d      = exit_q;
    ttw_d       = ttw_q;
    start_tmr_d = 1'b0;
    en_tmr_d    = 1'b0;
    osce_d      = '0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.substate <= 4'd9) begin
            state_d     = ARM;
            sub_d       = bus.substate;
            req_d       = req_of(bus.substate);
            ttw_d       = timer_of(bus.substate);
            start_tmr_d = 1'b1;
            en_tmr_d    = 1'b1;
          end else begin
            state_d  = DONE;
            finish_d = 1'b1;
            pass_d   = 1'b1;
            exit_d   = bus.substate;
            ttw_d    = 3'd0;
          end
        end
      end
      ARM: begin
        state_d  = COUNT;
        mask_d   = bus.activeLanes;
        en_tmr_d = 1'b1;
        osce_d   = bus.activeLanes;
        for (int i = 0; i < MAXLANES; i++) cnt_d[i] = '0;
      end
      COUNT: begin
        if (success) begin
          state_d  = DONE;
          finish_d = 1'b1;
          pass_d   = 1'b1;
          exit_d   = sub_q + 4'd1;
          ttw_d    = 3'd0;
        end else if (bus.timeOut && !met_next) begin
          state_d  = DONE;
          finish_d = 1'b1;
          pass_d   = 1'b0;
          exit_d   = 4'd0;
          ttw_d    = 3'd0;
        end else begin
          en_tmr_d = 1'b1;
          osce_d   = mask_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d     = IDLE;
      finish_d    = 1'b0;
      pass_d      = pass_q;
      exit_d      = exit_q;
      ttw_d       = 3'd0;
      start_tmr_d = 1'b0;
      en_tmr_d    = 1'b0;
      osce_d      = '0;
      for (int i = 0; i < MAXLANES; i++) cnt_d[i] = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_q       <= '0;
      req_q       <= '0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      pass_q      <= 1'b0;
      exit_q      <= '0;
      ttw_q       <= '0;
      start_tmr_q <= 1'b0;
      en_tmr_q    <= 1'b0;
      osce_q      <= '0;
      for (int i = 0; i < MAXLANES; i++) cnt[i] <= '0;
    end else begin
      sub_q       <= sub_d;
      req_q       <= req_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      pass_q      <= pass_d;
      exit_q      <= exit_d;
      ttw_q       <= ttw_d;
      start_tmr_q <= start_tmr_d;
      en_tmr_q    <= en_tmr_d;
      osce_q      <= osce_d;
      for (int i = 0; i < MAXLANES; i++) cnt[i] <= cnt_d[i];
    end
  end

  assign bus.busy            = busy_q;
  assign bus.finish          = finish_q;
  assign bus.pass            = pass_q;
  assign bus.exitTo          = exit_q;
  assign bus.timeToWait      = ttw_q;
  assign bus.startTimer      = start_tmr_q;
  assign bus.enableTimer     = en_tmr_q;
  assign bus.osCheckerEnable = osce_q;

endmodule

// File: tb/tb_rx_ltssm_exit_evaluator.sv
// Self-checking bench for rx_ltssm_exit_evaluator.
// Stimulus pushes the expected finish result (pass, exitTo) into a queue;
// a monitor pops and compares whenever the DUT pulses finish. Expected values
// come from a table-driven reference of the exit rules (required counts,
// timer durations, saturating per-lane totals).
module tb_rx_ltssm_exit_evaluator;
  localparam int MAXLANES = 16;
  localparam int CNTW     = 4;
  localparam int SAT      = (1 << CNTW) - 1;

  typedef struct packed {
    logic       pass;
    logic [3:0] exit_to;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference tables: required ordered sets and timer duration in ms.
  int req_tab[10]  = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 2};
  int wait_ms[10]  = '{12, 0, 24, 48, 24, 24, 2, 24, 24, 2};

  rx_ltssm_exit_evaluator_if #(.MAXLANES(MAXLANES)) bus ();

  rx_ltssm_exit_evaluator #(.MAXLANES(MAXLANES), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int ms_to_code(input int ms);
    case (ms)
      12:      return 1;
      24:      return 2;
      48:      return 3;
      2:       return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_finish(input logic p, input int e);
    exp_t x;
    x.pass    = p;
    x.exit_to = 4'(e);
    sb.push_back(x);
  endtask

  // Monitor: every finish pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t x;
    if (reset === 1'b1 && bus.finish === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_finish: got finish=1 pass=%0b exitTo=%0d, expected no finish", bus.pass, bus.exitTo);
      end else begin
        x = sb.pop_front();
        check_output("finish_pass", 32'(bus.pass), 32'(x.pass));
        check_output("finish_exitTo", 32'(bus.exitTo), 32'(x.exit_to));
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: busy=%b after %0d cycles, expected 0", name, bus.busy, budget);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      sb.delete();
    end
  endtask

  // Issue start, check ARM outputs, optionally pulse lanes during ARM, then
  // check first COUNT cycle outputs. Returns with inputs counted from next edge.
  task automatic apply_stimulus(input int sub, input logic [MAXLANES-1:0] mask, input logic [MAXLANES-1:0] arm_pulse);
    bus.substate    = 4'(sub);
    bus.activeLanes = mask;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check_output("arm_busy", 32'(bus.busy), 32'd1);
    if (sub <= 9) begin
      check_output("arm_startTimer", 32'(bus.startTimer), 32'd1);
      check_output("arm_enableTimer", 32'(bus.enableTimer), 32'd1);
      check_output("arm_timeToWait", 32'(bus.timeToWait), 32'(ms_to_code(wait_ms[sub])));
      bus.osValid = arm_pulse;
      tick();
      bus.osValid = '0;
      check_output("count_startTimer", 32'(bus.startTimer), 32'd0);
      check_output("count_enableTimer", 32'(bus.enableTimer), 32'd1);
      check_output("count_timeToWait", 32'(bus.timeToWait), 32'(ms_to_code(wait_ms[sub])));
      check_output("count_osCheckerEnable", 32'(bus.osCheckerEnable), 32'(mask));
    end
  endtask

  task automatic send_pulses(input int plan[MAXLANES]);
    int rem[MAXLANES];
    int left;
    logic [MAXLANES-1:0] v;
    rem = plan;
    for (int cyc = 0; cyc < 400; cyc++) begin
      left = 0;
      for (int i = 0; i < MAXLANES; i++) left += rem[i];
      if (left == 0) break;
      v = '0;
      for (int i = 0; i < MAXLANES; i++) begin
        if (rem[i] > 0 && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          rem[i]--;
        end
      end
      bus.osValid = v;
      tick();
    end
    bus.osValid = '0;
  endtask

  task automatic lanes_plan(output int plan[MAXLANES], input logic [MAXLANES-1:0] lanes, input int n);
    for (int i = 0; i < MAXLANES; i++) plan[i] = lanes[i] ? n : 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int plan[MAXLANES];
    int sub;
    int r;
    int k;
    logic [MAXLANES-1:0] mask;
    logic exp_pass;

    bus.start = 1'b0; bus.abort = 1'b0; bus.substate = '0;
    bus.activeLanes = '0; bus.osValid = '0;
    bus.rxElectricalIdle = 1'b1; bus.timeOut = 1'b0;
    reset = 1'b0;
    #12;
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    check_output("reset_finish", 32'(bus.finish), 32'd0);
    check_output("reset_pass", 32'(bus.pass), 32'd0);
    check_output("reset_exitTo", 32'(bus.exitTo), 32'd0);
    check_output("reset_timeToWait", 32'(bus.timeToWait), 32'd0);
    check_output("reset_startTimer", 32'(bus.startTimer), 32'd0);
    check_output("reset_enableTimer", 32'(bus.enableTimer), 32'd0);
    check_output("reset_osCheckerEnable", 32'(bus.osCheckerEnable), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // pollingActive, four lanes, eight ordered sets each.
    $display("[TB] substate 2 pass on lanes 0-3");
    expect_finish(1'b1, 3);
    apply_stimulus(2, 16'h000F, '0);
    lanes_plan(plan, 16'h000F, 8);
    send_pulses(plan);
    wait_idle("sub2_idle", 10);

    // Reset in the middle of counting drops every output at once.
    $display("[TB] asynchronous reset during COUNT");
    apply_stimulus(2, 16'h000F, '0);
    bus.osValid = 16'h000F;
    tick(); tick(); tick();
    bus.osValid = '0;
    reset = 1'b0;
    #1;
    check_output("midreset_busy", 32'(bus.busy), 32'd0);
    check_output("midreset_exitTo", 32'(bus.exitTo), 32'd0);
    check_output("midreset_pass", 32'(bus.pass), 32'd0);
    check_output("midreset_enableTimer", 32'(bus.enableTimer), 32'd0);
    check_output("midreset_timeToWait", 32'(bus.timeToWait), 32'd0);
    check_output("midreset_osCheckerEnable", 32'(bus.osCheckerEnable), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    expect_finish(1'b1, 3);
    apply_stimulus(2, 16'h000F, '0);
    lanes_plan(plan, 16'h000F, 8);
    send_pulses(plan);
    wait_idle("restart_idle", 10);

    // Lane 1 short of REQ, then timeout; a stray start mid-COUNT is ignored.
    $display("[TB] substate 4 fail on timeout");
    expect_finish(1'b0, 0);
    apply_stimulus(4, 16'h0003, '0);
    bus.substate = 4'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    plan = '{default: 0};
    plan[0] = 2; plan[1] = 1;
    send_pulses(plan);
    tick(); tick();
    check_output("sub4_still_busy", 32'(bus.busy), 32'd1);
    bus.timeOut = 1'b1;
    wait_idle("sub4_idle", 10);
    bus.timeOut = 1'b0;

    // Final ordered set coincides with timeOut: success wins.
    $display("[TB] substate 6 success beats timeout");
    expect_finish(1'b1, 7);
    apply_stimulus(6, 16'h0001, '0);
    bus.osValid = 16'h0001;
    tick();
    bus.osValid = '0;
    tick();
    bus.osValid = 16'h0001;
    bus.timeOut = 1'b1;
    tick();
    bus.osValid = '0;
    wait_idle("sub6_idle", 10);
    bus.timeOut = 1'b0;

    // detectQuiet exits when electrical idle falls.
    $display("[TB] substate 0 electrical idle exit");
    expect_finish(1'b1, 1);
    apply_stimulus(0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    check_output("sub0_waiting", 32'(bus.busy), 32'd1);
    bus.rxElectricalIdle = 1'b0;
    wait_idle("sub0_idle", 10);
    bus.rxElectricalIdle = 1'b1;

    // Bypass substate: finish one cycle after start.
    $display("[TB] bypass substate 10");
    expect_finish(1'b1, 10);
    bus.substate = 4'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_output("bypass_finish_n1", 32'(bus.finish), 32'd1);
    tick();
    check_output("bypass_finish_drop", 32'(bus.finish), 32'd0);
    check_output("bypass_busy_drop", 32'(bus.busy), 32'd0);

    // Abort mid-COUNT, then start immediately with substate 3.
    $display("[TB] abort then restart");
    apply_stimulus(2, 16'h000F, '0);
    bus.osValid = 16'h000F;
    tick(); tick(); tick();
    bus.osValid = '0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_enableTimer", 32'(bus.enableTimer), 32'd0);
    check_output("abort_exitTo_held", 32'(bus.exitTo), 32'd10);
    expect_finish(1'b1, 4);
    apply_stimulus(3, 16'h00F0, '0);
    lanes_plan(plan, 16'h00F0, 8);
    send_pulses(plan);
    wait_idle("sub3_idle", 10);

    // A pulse during ARM is not counted: one counted pulse is short of two.
    $display("[TB] pulse during ARM is dropped");
    expect_finish(1'b0, 0);
    apply_stimulus(9, 16'h0001, 16'h0001);
    bus.osValid = 16'h0001;
    tick();
    bus.osValid = '0;
    tick(); tick();
    bus.timeOut = 1'b1;
    wait_idle("armdrop_idle", 10);
    bus.timeOut = 1'b0;

    // 20 pulses must saturate at 15, not wrap below REQ.
    $display("[TB] counter saturation");
    expect_finish(1'b1, 3);
    apply_stimulus(2, 16'h0003, '0);
    plan = '{default: 0};
    plan[0] = 20; plan[1] = 7;
    send_pulses(plan);
    bus.osValid = 16'h0002;
    tick();
    bus.osValid = '0;
    wait_idle("sat_idle", 10);

    // Randomized runs against the reference rules.
    $display("[TB] randomized runs");
    for (int run = 0; run < 25; run++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        expect_finish(1'b1, 1);
        apply_stimulus(0, '0, '0);
        k = $urandom_range(0, 6);
        for (int i = 0; i < k; i++) tick();
        if ($urandom_range(0, 1) == 1) bus.rxElectricalIdle = 1'b0;
        else bus.timeOut = 1'b1;
        wait_idle("rand_sub0", 10);
        bus.rxElectricalIdle = 1'b1;
        bus.timeOut = 1'b0;
      end else if (r == 1) begin
        expect_finish(1'b1, 2);
        apply_stimulus(1, '0, '0);
        k = $urandom_range(0, 6);
        for (int i = 0; i < k; i++) tick();
        bus.timeOut = 1'b1;
        wait_idle("rand_sub1", 10);
        bus.timeOut = 1'b0;
      end else if (r == 2) begin
        sub = $urandom_range(10, 15);
        expect_finish(1'b1, sub);
        apply_stimulus(sub, '0, '0);
        wait_idle("rand_bypass", 5);
      end else begin
        sub = $urandom_range(2, 9);
        mask = 16'($urandom & $urandom);
        if ($urandom_range(0, 7) == 0) mask = '0;
        for (int i = 0; i < MAXLANES; i++) begin
          if ($urandom_range(0, 3) == 0) plan[i] = $urandom_range(0, req_tab[sub] - 1);
          else plan[i] = $urandom_range(req_tab[sub], 20);
        end
        exp_pass = (mask != '0);
        for (int i = 0; i < MAXLANES; i++) begin
          if (mask[i] && ((plan[i] > SAT) ? SAT : plan[i]) < req_tab[sub]) exp_pass = 1'b0;
        end
        expect_finish(exp_pass, exp_pass ? sub + 1 : 0);
        apply_stimulus(sub, mask, '0);
        send_pulses(plan);
        tick(); tick();
        if (bus.busy === 1'b1) bus.timeOut = 1'b1;
        wait_idle("rand_count", 10);
        bus.timeOut = 1'b0;
      end
      tick();
    end

    tick(); tick();
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
